// File: rtl/axi4l_add_engine_slave.sv
// AXI4-Lite register slave wrapping a sequential 32-bit add/accumulate engine.
// Software loads OPA/OPB, pulses START, then polls DONE (or waits on irq) and reads RESULT.
module axi4l_add_engine_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int ADD_LATENCY        = 2
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            irq
);

    localparam int               CNT_W       = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(ADD_LATENCY - 1);
    localparam logic [1:0]       RESP_OKAY   = 2'b00;
    localparam logic [1:0]       RESP_SLVERR = 2'b10;
    localparam logic [1:0]       A_OPA       = 2'd0;
    localparam logic [1:0]       A_OPB       = 2'd1;
    localparam logic [1:0]       A_CTRL      = 2'd2;
    localparam logic [1:0]       A_RESULT    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_live;
    logic              r_aw_held;
    logic              r_w_held;
    logic [1:0]        r_wr_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic              r_bvalid;
    logic [1:0]        r_bresp;
    logic              r_rvalid;
    logic [31:0]       r_rdata;

    logic [31:0]       r_opa;
    logic [31:0]       r_opb;
    logic [31:0]       r_result;
    logic              r_carry;
    logic              r_acc;
    logic              r_ie;
    logic              r_done;
    logic [32:0]       r_sum;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_awready;
    logic              w_wready;
    logic              w_arready;
    logic              w_wr_go;
    logic              w_ctrl_wr;
    logic              w_start_req;
    logic              w_start;
    logic              w_done_clr;
    logic              w_busy;
    logic              w_run_end;
    logic              w_wr_err;
    logic [31:0]       w_opb_sel;
    logic [31:0]       w_rd_mux;
    logic              w_unused;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        end
        return res;
    endfunction

    // r_live keeps every READY low until the first clock after reset release
    assign w_awready = r_live && !r_aw_held && !r_bvalid;
    assign w_wready  = r_live && !r_w_held && !r_bvalid;
    assign w_arready = r_live && !r_rvalid && S_AXI_ARVALID;

    assign w_wr_go     = r_aw_held && r_w_held && !r_bvalid;
    assign w_ctrl_wr   = w_wr_go && (r_wr_addr == A_CTRL) && r_wstrb[0];
    assign w_busy      = (r_state == ST_RUN);
    assign w_start_req = w_ctrl_wr && r_wdata[0];
    assign w_start     = w_start_req && !w_busy;
    assign w_done_clr  = w_ctrl_wr && r_wdata[3];
    assign w_run_end   = (r_state == ST_RUN) && (r_cnt == '0);
    assign w_wr_err    = (r_wr_addr == A_RESULT) || (w_start_req && w_busy);
    // ACC comes from the START write itself so CTRL=0x3 accumulates immediately
    assign w_opb_sel   = r_wdata[1] ? r_result : r_opb;

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_live    <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_wr_addr <= 2'd0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            r_live <= 1'b1;
            if (S_AXI_AWVALID && w_awready) begin
                r_aw_held <= 1'b1;
                r_wr_addr <= S_AXI_AWADDR[3:2];
            end
            if (S_AXI_WVALID && w_wready) begin
                r_w_held <= 1'b1;
                r_wdata  <= S_AXI_WDATA;
                r_wstrb  <= S_AXI_WSTRB;
            end
            if (w_wr_go) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (r_bvalid && S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_opa <= 32'd0;
            r_opb <= 32'd0;
            r_acc <= 1'b0;
            r_ie  <= 1'b0;
        end else if (w_wr_go) begin
            case (r_wr_addr)
                A_OPA:   r_opa <= f_merge(r_opa, r_wdata, r_wstrb);
                A_OPB:   r_opb <= f_merge(r_opb, r_wdata, r_wstrb);
                A_CTRL: begin
                    if (r_wstrb[0]) begin
                        r_acc <= r_wdata[1];
                        r_ie  <= r_wdata[2];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_nxt = ST_RUN;
            ST_RUN:  if (r_cnt == '0) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = w_start ? ST_RUN : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operands are captured as RUN begins, so later OPA/OPB writes cannot disturb the sum
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_sum    <= 33'd0;
            r_cnt    <= '0;
            r_result <= 32'd0;
            r_carry  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            if (w_start) begin
                r_sum <= {1'b0, r_opa} + {1'b0, w_opb_sel};
                r_cnt <= CNT_LOAD;
            end else if (w_busy && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_run_end) begin
                r_result <= r_sum[31:0];
                r_carry  <= r_sum[32];
            end
            if (w_run_end) begin
                r_done <= 1'b1;
            end else if (w_start || w_done_clr) begin
                r_done <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rd_mux = 32'd0;
        case (S_AXI_ARADDR[3:2])
            A_OPA:    w_rd_mux = r_opa;
            A_OPB:    w_rd_mux = r_opb;
            A_CTRL:   w_rd_mux = {21'd0, r_carry, r_done, w_busy, 5'd0, r_ie, r_acc, 1'b0};
            A_RESULT: w_rd_mux = r_result;
            default:  w_rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 32'd0;
        end else if (w_arready) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_mux;
        end else if (r_rvalid && S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

    assign S_AXI_AWREADY = w_awready;
    assign S_AXI_WREADY  = w_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = w_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign irq           = r_done && r_ie;

endmodule

// File: tb/tb_axi4l_add_engine_slave.sv
// Scoreboarded bench for axi4l_add_engine_slave: expected BRESP/RDATA are queued at issue
// and popped when the response channel fires.
module tb_axi4l_add_engine_slave;

    localparam int LAT = 6;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [3:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        irq;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [1:0]  bq[$];
    logic [31:0] rq[$];

    always #5 clk = ~clk;

    axi4l_add_engine_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4),
        .ADD_LATENCY        (LAT)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .irq           (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic axi_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] er, input string tag);
        logic aw_f, w_f;
        logic [1:0] e;
        int n;
        bq.push_back(er);
        @(posedge clk); #1;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 50) begin
            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_f) awvalid = 1'b0;
            if (w_f)  wvalid = 1'b0;
            n++;
        end
        while (!bvalid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        e = bq.pop_front();
        if (!bvalid) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            awvalid = 1'b0;
            wvalid  = 1'b0;
        end else begin
            chk(tag, {30'd0, bresp}, {30'd0, e});
        end
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic rd_raw(input logic [3:0] a, output logic [31:0] v, output logic ok);
        int n;
        @(posedge clk); #1;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (arvalid && n < 50) begin
            if (arready) begin
                @(posedge clk); #1;
                arvalid = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
            n++;
        end
        while (!rvalid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        ok = rvalid;
        v  = rdata;
        arvalid = 1'b0;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic axi_rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] v, e;
        logic ok;
        rq.push_back(exp);
        rd_raw(a, v, ok);
        e = rq.pop_front();
        if (!ok) chk({tag, "_timeout"}, 32'd0, 32'd1);
        else     chk(tag, v, e);
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] v;
        logic ok;
        v = '0;
        for (int k = 0; k < 30 && !v[9]; k++) rd_raw(4'h8, v, ok);
        chk(tag, {31'd0, v[9]}, 32'd1);
    endtask

    initial begin
        logic [1:0] e;
        int n_aw;
        int n;

        #2;
        chk("reset_outs", {22'd0, awready, wready, bvalid, bresp, arready, rvalid, rresp, irq}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        axi_rd(4'h0, 32'd0, "rst_opa");
        axi_rd(4'h4, 32'd0, "rst_opb");
        axi_rd(4'h8, 32'd0, "rst_ctrl");
        axi_rd(4'hC, 32'd0, "rst_result");

        // basic add, with BUSY visible right after START
        axi_wr(4'h0, 32'd1, 4'hF, OKAY, "wr_opa1");
        axi_wr(4'h4, 32'd2, 4'hF, OKAY, "wr_opb2");
        axi_wr(4'h8, 32'h1, 4'hF, OKAY, "wr_start1");
        axi_rd(4'h8, 32'h100, "busy_bit");
        wait_done("done_add");
        axi_rd(4'h8, 32'h200, "ctrl_done");
        axi_rd(4'hC, 32'h3, "res_3");

        // carry out of bit 31
        axi_wr(4'h0, 32'hFFFF_FFFF, 4'hF, OKAY, "wr_opa_ff");
        axi_wr(4'h4, 32'h2, 4'hF, OKAY, "wr_opb_2");
        axi_wr(4'h8, 32'h1, 4'hF, OKAY, "wr_start2");
        wait_done("done_carry");
        axi_rd(4'hC, 32'h1, "res_wrap");
        axi_rd(4'h8, 32'h600, "ctrl_carry");
        axi_wr(4'h8, 32'h8, 4'hF, OKAY, "wr_doneclr");
        axi_rd(4'h8, 32'h400, "ctrl_clr");

        // accumulate and irq
        axi_wr(4'h0, 32'd1, 4'hF, OKAY, "acc_opa1");
        axi_wr(4'h8, 32'h1, 4'hF, OKAY, "acc_start0");
        wait_done("acc_done0");
        axi_rd(4'hC, 32'd3, "acc_res3");
        axi_wr(4'h0, 32'd5, 4'hF, OKAY, "acc_opa5");
        axi_wr(4'h8, 32'h3, 4'hF, OKAY, "acc_start1");
        wait_done("acc_done1");
        axi_rd(4'hC, 32'd8, "acc_res8");
        axi_wr(4'h8, 32'h3, 4'hF, OKAY, "acc_start2");
        wait_done("acc_done2");
        axi_rd(4'hC, 32'd13, "acc_res13");
        axi_rd(4'h8, 32'h202, "acc_ctrl");
        chk("irq_ie0", {31'd0, irq}, 32'd0);
        axi_wr(4'h8, 32'h6, 4'hF, OKAY, "wr_ie");
        chk("irq_on", {31'd0, irq}, 32'd1);
        axi_rd(4'h8, 32'h206, "ctrl_ie");
        axi_wr(4'h8, 32'hE, 4'hF, OKAY, "wr_ie_clr");
        chk("irq_off", {31'd0, irq}, 32'd0);
        axi_rd(4'h8, 32'h006, "ctrl_ie_clr");

        // AW three cycles ahead of W, BREADY withheld for four cycles
        bq.push_back(OKAY);
        @(posedge clk); #1;
        awaddr = 4'h0; awvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF; bready = 1'b0;
        n_aw = 0;
        for (int i = 0; i < 3; i++) begin
            if (awvalid && awready) n_aw++;
            @(posedge clk); #1;
            awaddr = 4'h4;
        end
        wvalid = 1'b1;
        chk("early_aw_wready", {31'd0, wready}, 32'd1);
        @(posedge clk); #1;
        wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin
            if (awvalid && awready) n_aw++;
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            chk("bvalid_hold", {31'd0, bvalid}, 32'd1);
            if (awvalid && awready) n_aw++;
            @(posedge clk); #1;
        end
        e = bq.pop_front();
        chk("split_bresp", {30'd0, bresp}, {30'd0, e});
        awvalid = 1'b0;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        chk("bvalid_drop", {31'd0, bvalid}, 32'd0);
        chk("aw_accepts", n_aw, 32'd1);
        axi_rd(4'h0, 32'h55, "split_opa");
        axi_rd(4'h4, 32'h2, "split_opb");

        // write to RESULT is rejected
        axi_wr(4'hC, 32'h1234_5678, 4'hF, SLVERR, "wr_result_err");
        axi_rd(4'hC, 32'd13, "res_kept");

        // START while busy is rejected; the first START alone defines RESULT
        axi_wr(4'h0, 32'd10, 4'hF, OKAY, "busy_opa");
        axi_wr(4'h4, 32'd20, 4'hF, OKAY, "busy_opb");
        axi_wr(4'h8, 32'h1, 4'hF, OKAY, "busy_start_ok");
        axi_wr(4'h8, 32'h3, 4'hF, SLVERR, "busy_start_err");
        wait_done("busy_done");
        axi_rd(4'hC, 32'd30, "busy_res");

        // byte strobes
        axi_wr(4'h0, 32'h1122_3344, 4'hF, OKAY, "strb_full");
        axi_wr(4'h0, 32'hAABB_CCDD, 4'h1, OKAY, "strb_b0");
        axi_rd(4'h0, 32'h1122_33DD, "strb_opa");
        axi_wr(4'h4, 32'hAABB_CCDD, 4'hA, OKAY, "strb_b13");
        axi_rd(4'h4, 32'hAA00_CC14, "strb_opb");

        // reset in the middle of RUN
        axi_wr(4'h0, 32'd7, 4'hF, OKAY, "rr_opa");
        axi_wr(4'h8, 32'h5, 4'hF, OKAY, "rr_start");
        rst_n = 1'b0;
        #1;
        chk("rr_outs", {22'd0, awready, wready, bvalid, bresp, arready, rvalid, rresp, irq}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (LAT + 4) @(posedge clk);
        #1;
        chk("rr_irq", {31'd0, irq}, 32'd0);
        axi_rd(4'h0, 32'd0, "rr_opa0");
        axi_rd(4'h4, 32'd0, "rr_opb0");
        axi_rd(4'h8, 32'd0, "rr_ctrl0");
        axi_rd(4'hC, 32'd0, "rr_res0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
